spu_loader: RTL and testbench
=============================

SPU_LOADER -- requirements
Module: spu_loader

Interface
REQ-001 Parameter LS_BYTES, default 262144, local store size in bytes (power of two, multiple of 16).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  single-cycle request to begin a program load; sampled only in IDLE or DONE.
REQ-005 start_addr  in  32  local-store byte address of the first quadword; bits [28:31] must be zero.
REQ-006 len_qw  in  15  number of quadwords to load, 0..16384.
REQ-007 abort  in  1  cancels an active load.
REQ-008 host_data  in  32  instruction word from the host stream; bit 0 is the MSB.
REQ-009 host_valid / host_ready  in / out  1 / 1  host-stream handshake; a word transfers on a clock where both are high.
REQ-010 ls_addr  out  32  local-store byte address of the current write.
REQ-011 ls_data_wr  out  128  quadword to write.
REQ-012 ls_wr_en  out  1  local-store write strobe.
REQ-013 busy  out  1  high in COLLECT and WRITE.
REQ-014 load_done  out  1  high in DONE.
REQ-015 err  out  1  sticky misalignment flag; cleared by the next accepted start.
REQ-016 spu_run  out  1  release for the SPU core; low holds the core in reset.

Function
REQ-017 States: IDLE, COLLECT, WRITE, DONE. The FSM is encoded as an enum.
REQ-018 IDLE or DONE, with start=1 and start_addr[28:31]=0 and len_qw>0: latch the address and length, clear the word counter, clear err, drop spu_run, and go to COLLECT.
REQ-019 IDLE or DONE, with start=1 and start_addr[28:31]!=0: set err, make no local-store write, and go to IDLE with spu_run=0.
REQ-020 IDLE or DONE, with start=1, aligned address and len_qw=0: go directly to DONE with no writes.
REQ-021 COLLECT: host_ready=1 while fewer than 4 words are held; host_ready is 0 in every other state.
REQ-022 Placement of accepted words: word k (k=0..3) goes to quadword bits [32k : 32k+31]; the first word received occupies bits [0:31].
REQ-023 When the fourth word is accepted, the next state is WRITE.
REQ-024 WRITE: ls_wr_en=1 for exactly one cycle, carrying the latched ls_addr and quadword.
REQ-025 After each write: address += 16, modulo LS_BYTES (wraps to 0); remaining count -= 1.
REQ-026 After the write, go to DONE if the remaining count is 0, otherwise return to COLLECT.
REQ-027 Throughput: at most one quadword per 5 cycles (4 accept cycles plus 1 write cycle).
REQ-028 ls_addr and ls_data_wr are registered; they hold their last value whenever ls_wr_en=0.
REQ-029 DONE: load_done=1 and spu_run=1; both remain high until the next accepted start.
REQ-030 abort in COLLECT or WRITE: the partial quadword is discarded, no write occurs in the next cycle, the FSM goes to IDLE, and spu_run=0.
REQ-031 abort in IDLE or DONE has no effect.
REQ-032 abort and start in the same cycle: abort has priority and start is ignored.
REQ-033 start during COLLECT or WRITE is ignored.
REQ-034 A host_valid=0 gap of any length stalls COLLECT without losing the words already held.

Reset
REQ-035 rst=0 asynchronously forces all of the following: state IDLE; every output 0 (host_ready, ls_wr_en, busy, load_done, err, spu_run); ls_addr and ls_data_wr all zero; counters zero.
REQ-036 Reset asserted mid-load abandons the load; the first start after reset deasserts begins a new load.

Structure
REQ-037 The loader FSM state typedef and the LS_BYTES default constant belong in defines_pkg.
REQ-038 One sub-module, qw_assembler, is natural: 32-to-128 word packing with a count and a full flag.
REQ-039 spu_loader sits upstream of spu_top: it drives local_store write ports and the SPU reset.

Verification
REQ-040 Load with start_addr=0x100, len_qw=2, 8 back-to-back words 0x00000001..0x00000008. Required response:
- write 1: ls_addr 0x100, data 0x00000001_00000002_00000003_00000004
- write 2: ls_addr 0x110, data 0x00000005..0x00000008
- then load_done=1 and spu_run=1.
REQ-041 Wrap: start_addr=LS_BYTES-16, len_qw=2 -> writes at LS_BYTES-16, then at 0x0.
REQ-042 Misaligned start: start_addr=0x104 -> err=1, no ls_wr_en, host_ready stays 0.
REQ-043 Abort after 3 words accepted -> no write, state IDLE, spu_run=0. A following load with len_qw=1 writes only the new 4 words.
REQ-044 Backpressure and gaps: host_valid toggles randomly, len_qw=3 -> exactly 3 writes with correct data order, and host_ready=0 during each WRITE cycle.
REQ-045 Reset: rst pulsed low mid-COLLECT with no clock edge -> outputs go to 0 immediately; len_qw=0 start after reset -> DONE next cycle with zero writes.

Source files
------------

// File: rtl/defines_pkg.sv
// Shared types and constants for the SPU program loader.
// Holds the loader FSM state encoding and the default local-store size.
package defines_pkg;

    localparam int LS_BYTES_DEFAULT = 262144;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE
    } loader_state_t;

    // Only the low nibble of a byte address matters for quadword alignment.
    function automatic logic is_qw_aligned(input logic [3:0] addr_low);
        return addr_low == 4'h0;
    endfunction

endpackage

// File: rtl/qw_assembler.sv
// Packs four 32-bit host words into one 128-bit quadword, first word in the MSBs.
// Exposes the quadword including the word being accepted this cycle.
module qw_assembler (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         word_valid,
    input  logic [31:0]  word,
    output logic [127:0] packed_qw,
    output logic [2:0]   count,
    output logic         full
);

    logic [127:0] qw_q;

    assign full = (count == 3'd4);

    // NOTE: always_comb gets a full default first so no path can infer a latch.
    always_comb begin
        packed_qw = qw_q;
        if (word_valid && !full) begin
            case (count[1:0])
                2'd0:    packed_qw[127:96] = word;
                2'd1:    packed_qw[95:64]  = word;
                2'd2:    packed_qw[63:32]  = word;
                default: packed_qw[31:0]   = word;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qw_q  <= '0;
            count <= '0;
        end else if (clear) begin
            qw_q  <= '0;
            count <= '0;
        end else if (word_valid && !full) begin
            qw_q  <= packed_qw;
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/spu_loader.sv
// Streams a program from the host into SPU local store one quadword at a time,
// then releases the SPU core from reset.
module spu_loader
    import defines_pkg::*;
#(
    parameter int LS_BYTES = LS_BYTES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  start_addr,
    input  logic [14:0]  len_qw,
    input  logic         abort,
    input  logic [31:0]  host_data,
    input  logic         host_valid,
    output logic         host_ready,
    output logic [31:0]  ls_addr,
    output logic [127:0] ls_data_wr,
    output logic         ls_wr_en,
    output logic         busy,
    output logic         load_done,
    output logic         err,
    output logic         spu_run
);

    localparam logic [31:0] ADDR_MASK = 32'(LS_BYTES - 1);

    loader_state_t state;
    logic [31:0]   cur_addr;
    logic [14:0]   remaining;
    logic          start_go;
    logic          accept;
    logic          asm_clear;
    logic          asm_full;
    logic [2:0]    asm_count;
    logic [127:0]  asm_packed;

    // Abort wins over start in every state.
    assign start_go  = (state == ST_IDLE || state == ST_DONE) && start && !abort;
    assign accept    = host_valid && host_ready && !asm_full && !abort;
    assign asm_clear = start_go || abort || (state == ST_WRITE);

    qw_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .word_valid (accept),
        .word       (host_data),
        .packed_qw  (asm_packed),
        .count      (asm_count),
        .full       (asm_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            host_ready <= 1'b0;
            ls_addr    <= '0;
            ls_data_wr <= '0;
            ls_wr_en   <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            err        <= 1'b0;
            spu_run    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_go) begin
                        if (!is_qw_aligned(start_addr[3:0])) begin
                            err       <= 1'b1;
                            load_done <= 1'b0;
                            spu_run   <= 1'b0;
                            state     <= ST_IDLE;
                        end else if (len_qw == '0) begin
                            err       <= 1'b0;
                            load_done <= 1'b1;
                            spu_run   <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            cur_addr   <= start_addr;
                            remaining  <= len_qw;
                            err        <= 1'b0;
                            load_done  <= 1'b0;
                            spu_run    <= 1'b0;
                            busy       <= 1'b1;
                            host_ready <= 1'b1;
                            state      <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (abort) begin
                        busy       <= 1'b0;
                        host_ready <= 1'b0;
                        spu_run    <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (accept && asm_count == 3'd3) begin
                        // Fourth word: capture the finished quadword for next cycle's write.
                        host_ready <= 1'b0;
                        ls_wr_en   <= 1'b1;
                        ls_addr    <= cur_addr;
                        ls_data_wr <= asm_packed;
                        state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    ls_wr_en <= 1'b0;
                    if (abort) begin
                        busy    <= 1'b0;
                        spu_run <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        cur_addr  <= (cur_addr + 32'd16) & ADDR_MASK;
                        remaining <= remaining - 15'd1;
                        if (remaining == 15'd1) begin
                            busy      <= 1'b0;
                            load_done <= 1'b1;
                            spu_run   <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            host_ready <= 1'b1;
                            state      <= ST_COLLECT;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spu_loader.sv
// Directed bench for spu_loader: table of load vectors plus hand-written
// abort, backpressure and reset sequences.
module tb_spu_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  start_addr;
    logic [14:0]  len_qw;
    logic         abort;
    logic [31:0]  host_data;
    logic         host_valid;
    logic         host_ready;
    logic [31:0]  ls_addr;
    logic [127:0] ls_data_wr;
    logic         ls_wr_en;
    logic         busy;
    logic         load_done;
    logic         err;
    logic         spu_run;

    int total = 0;
    int bad   = 0;
    int ready_bad = 0;
    logic [31:0]  wr_addr_q[$];
    logic [127:0] wr_data_q[$];

    spu_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len_qw     (len_qw),
        .abort      (abort),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .ls_addr    (ls_addr),
        .ls_data_wr (ls_data_wr),
        .ls_wr_en   (ls_wr_en),
        .busy       (busy),
        .load_done  (load_done),
        .err        (err),
        .spu_run    (spu_run)
    );

    always #5 clk = ~clk;

    // Capture every local-store write mid-cycle.
    always @(negedge clk) begin
        if (ls_wr_en) begin
            wr_addr_q.push_back(ls_addr);
            wr_data_q.push_back(ls_data_wr);
            if (host_ready) ready_bad++;
        end
    end

    typedef struct {
        logic [31:0]  addr;
        logic [14:0]  len;
        logic [31:0]  seed;
        int           exp_writes;
        logic         exp_err;
        logic         exp_done;
        logic [31:0]  exp_a0;
        logic [31:0]  exp_a1;
        logic [127:0] exp_d0;
        logic [127:0] exp_d1;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        ready_bad = 0;
    endtask

    // Pulse start, then stream seed, seed+1, ... while the loader is busy.
    task automatic run_load(input logic [31:0] addr, input logic [14:0] len,
                            input logic [31:0] seed, input bit gappy);
        int  idx;
        int  guard;
        logic xfer;
        clear_log();
        start = 1'b1;
        start_addr = addr;
        len_qw = len;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        guard = 0;
        while (busy && guard < 400) begin
            host_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            host_data  = seed + 32'(idx);
            xfer = host_valid && host_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
            guard++;
        end
        host_valid = 1'b0;
        check("load_timeout", 128'(guard >= 400), 128'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int   idx;
        int   guard;
        logic xfer;

        vecs[0] = '{32'h0000_0100, 15'd2, 32'h1, 2, 1'b0, 1'b1, 32'h100, 32'h110,
                    128'h00000001_00000002_00000003_00000004,
                    128'h00000005_00000006_00000007_00000008};
        vecs[1] = '{32'h0003_FFF0, 15'd2, 32'hA0, 2, 1'b0, 1'b1, 32'h3FFF0, 32'h0,
                    128'h000000A0_000000A1_000000A2_000000A3,
                    128'h000000A4_000000A5_000000A6_000000A7};
        vecs[2] = '{32'h0000_0104, 15'd2, 32'h50, 0, 1'b1, 1'b0, 32'h0, 32'h0, 128'h0, 128'h0};
        vecs[3] = '{32'h0000_0200, 15'd0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 32'h0, 128'h0, 128'h0};
        vecs[4] = '{32'h0000_3000, 15'd1, 32'hDEAD_0000, 1, 1'b0, 1'b1, 32'h3000, 32'h0,
                    128'hDEAD0000_DEAD0001_DEAD0002_DEAD0003, 128'h0};
        vecs[5] = '{32'h0000_000F, 15'd1, 32'h60, 0, 1'b1, 1'b0, 32'h0, 32'h0, 128'h0, 128'h0};

        rst = 1'b0;
        start = 1'b0;
        start_addr = '0;
        len_qw = '0;
        abort = 1'b0;
        host_data = '0;
        host_valid = 1'b0;
        #12;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ready", 128'(host_ready), 128'd0);
        check("rst_run", 128'(spu_run), 128'd0);
        check("rst_addr", 128'(ls_addr), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_load(vecs[i].addr, vecs[i].len, vecs[i].seed, 1'b0);
            check($sformatf("v%0d_writes", i), 128'(wr_addr_q.size()), 128'(vecs[i].exp_writes));
            if (vecs[i].exp_writes >= 1 && wr_addr_q.size() >= 1) begin
                check($sformatf("v%0d_addr0", i), 128'(wr_addr_q[0]), 128'(vecs[i].exp_a0));
                check($sformatf("v%0d_data0", i), wr_data_q[0], vecs[i].exp_d0);
            end
            if (vecs[i].exp_writes >= 2 && wr_addr_q.size() >= 2) begin
                check($sformatf("v%0d_addr1", i), 128'(wr_addr_q[1]), 128'(vecs[i].exp_a1));
                check($sformatf("v%0d_data1", i), wr_data_q[1], vecs[i].exp_d1);
            end
            check($sformatf("v%0d_err", i), 128'(err), 128'(vecs[i].exp_err));
            check($sformatf("v%0d_done", i), 128'(load_done), 128'(vecs[i].exp_done));
            check($sformatf("v%0d_run", i), 128'(spu_run), 128'(vecs[i].exp_done));
            check($sformatf("v%0d_ready", i), 128'(host_ready), 128'd0);
            check($sformatf("v%0d_busy", i), 128'(busy), 128'd0);
        end

        // Backpressure: random host_valid gaps across three quadwords.
        run_load(32'h0000_1230, 15'd3, 32'h1111_0000, 1'b1);
        check("bp_writes", 128'(wr_addr_q.size()), 128'd3);
        if (wr_addr_q.size() == 3) begin
            check("bp_addr0", 128'(wr_addr_q[0]), 128'h1230);
            check("bp_addr2", 128'(wr_addr_q[2]), 128'h1250);
            check("bp_data0", wr_data_q[0], 128'h11110000_11110001_11110002_11110003);
            check("bp_data1", wr_data_q[1], 128'h11110004_11110005_11110006_11110007);
            check("bp_data2", wr_data_q[2], 128'h11110008_11110009_1111000A_1111000B);
        end
        check("bp_ready_in_write", 128'(ready_bad), 128'd0);
        check("bp_done", 128'(load_done), 128'd1);

        // Abort after three words, then a fresh single-quadword load.
        clear_log();
        start = 1'b1;
        start_addr = 32'h800;
        len_qw = 15'd2;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < 3 && guard < 100) begin
            host_valid = 1'b1;
            host_data = 32'hBAD0_0000 + 32'(idx);
            xfer = host_ready;
            @(posedge clk); #1;
            if (xfer) idx++;
            guard++;
        end
        host_valid = 1'b0;
        check("abort_feed_timeout", 128'(guard >= 100), 128'd0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_run", 128'(spu_run), 128'd0);
        check("abort_ready", 128'(host_ready), 128'd0);
        check("abort_done", 128'(load_done), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_writes", 128'(wr_addr_q.size()), 128'd0);

        // Abort and start together in IDLE: start must be ignored.
        start = 1'b1;
        abort = 1'b1;
        start_addr = 32'h400;
        len_qw = 15'd1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", 128'(busy), 128'd0);

        run_load(32'h0000_0900, 15'd1, 32'h77, 1'b0);
        check("post_abort_writes", 128'(wr_addr_q.size()), 128'd1);
        if (wr_addr_q.size() == 1) begin
            check("post_abort_addr", 128'(wr_addr_q[0]), 128'h900);
            check("post_abort_data", wr_data_q[0], 128'h00000077_00000078_00000079_0000007A);
        end

        // Abort in DONE is ignored.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("done_abort_done", 128'(load_done), 128'd1);
        check("done_abort_run", 128'(spu_run), 128'd1);

        // Asynchronous reset mid-COLLECT, between clock edges.
        clear_log();
        start = 1'b1;
        start_addr = 32'h500;
        len_qw = 15'd2;
        @(posedge clk); #1;
        start = 1'b0;
        host_valid = 1'b1;
        host_data = 32'h5555_0000;
        repeat (2) @(posedge clk);
        #2;
        host_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_ready", 128'(host_ready), 128'd0);
        check("arst_addr", 128'(ls_addr), 128'd0);
        check("arst_data", ls_data_wr, 128'd0);
        check("arst_done", 128'(load_done), 128'd0);
        check("arst_run", 128'(spu_run), 128'd0);
        check("arst_wr_en", 128'(ls_wr_en), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = 32'h600;
        len_qw = 15'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_len_done", 128'(load_done), 128'd1);
        check("zero_len_run", 128'(spu_run), 128'd1);
        check("zero_len_busy", 128'(busy), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        check("zero_len_writes", 128'(wr_addr_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
